// File: rtl/decodificador_n_varredura.sv
// decodificador_n_varredura: registered N-to-2^N one-hot decoder with a
// direct decode mode and a timed one-hot sweep mode, plus an inhibit mask.
module decodificador_n_varredura #(
  parameter int LARGURA     = 2,
  parameter int PERMANENCIA = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  modo,
  input  logic                  inibe,
  input  logic [LARGURA-1:0]    codigo,
  input  logic                  codigo_valido,
  output logic [2**LARGURA-1:0] y,
  output logic [LARGURA-1:0]    indice,
  output logic                  y_valido,
  output logic                  fim_varredura
);

  localparam int SAIDAS = 2**LARGURA;
  localparam int LP =
    (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;

  localparam logic [LP-1:0] ULTIMO_CICLO =
    LP'(PERMANENCIA - 1);
  localparam logic [LARGURA-1:0] ULTIMA_SAIDA =
    LARGURA'(SAIDAS - 1);
  localparam logic [SAIDAS-1:0] UM = SAIDAS'(1);

  typedef enum logic [1:0] {
    OCIOSO,
    DIRETO,
    VARREDURA
  } estado_t;

  estado_t             estado;
  estado_t             prox_estado;
  logic [LP-1:0]       perm;
  logic [LP-1:0]       prox_perm;
  logic [SAIDAS-1:0]   prox_y;
  logic [LARGURA-1:0]  prox_indice;
  logic                prox_valido;
  logic                prox_fim;
  logic                retido;
  logic                prox_retido;
  logic                pausado;
  logic                prox_pausado;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= OCIOSO;
      y             <= '0;
      indice        <= '0;
      y_valido      <= 1'b0;
      fim_varredura <= 1'b0;
      perm          <= '0;
      retido        <= 1'b0;
      pausado       <= 1'b0;
    end else begin
      estado        <= prox_estado;
      y             <= prox_y;
      indice        <= prox_indice;
      y_valido      <= prox_valido;
      fim_varredura <= prox_fim;
      perm          <= prox_perm;
      retido        <= prox_retido;
      pausado       <= prox_pausado;
    end
  end

  // retido: DIRETO currently holds an accepted code
  // pausado: previous edge was masked, so a sweep resumes with fresh dwell
  always_comb begin
    prox_estado  = estado;
    prox_y       = y;
    prox_indice  = indice;
    prox_valido  = y_valido;
    prox_fim     = 1'b0;
    prox_perm    = perm;
    prox_retido  = retido;
    prox_pausado = 1'b0;

    if (inibe) begin
      prox_y       = '0;
      prox_valido  = 1'b0;
      prox_pausado = 1'b1;
    end else if (modo) begin
      prox_estado = VARREDURA;
      prox_valido = 1'b1;
      if (estado != VARREDURA) begin
        prox_indice = '0;
        prox_perm   = '0;
      end else if (pausado) begin
        prox_perm = '0;
      end else if (perm == ULTIMO_CICLO) begin
        prox_perm   = '0;
        prox_indice = indice + 1'b1;
        prox_fim    = (indice == ULTIMA_SAIDA);
      end else begin
        prox_perm = perm + 1'b1;
      end
      prox_y = UM << prox_indice;
    end else begin
      if (codigo_valido) begin
        prox_estado = DIRETO;
        prox_indice = codigo;
        prox_retido = 1'b1;
      end else if (estado == VARREDURA) begin
        prox_estado = DIRETO;
        prox_retido = 1'b0;
      end
      prox_valido = prox_retido;
      prox_y      = prox_retido ? (UM << prox_indice) : '0;
    end
  end

endmodule

// File: tb/tb_decodificador_n_varredura.sv
// Bench for decodificador_n_varredura: directed scenarios plus a
// randomized run checked against a cycle-count based reference model.
module tb_decodificador_n_varredura;

  localparam int L = 2;
  localparam int P = 4;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       modo = 1'b0;
  logic       inibe = 1'b0;
  logic       codigo_valido = 1'b0;
  logic [1:0] codigo = '0;
  logic [3:0] y;
  logic [1:0] indice;
  logic       y_valido;
  logic       fim_varredura;

  logic [2:0] codigo_b = '0;
  logic [7:0] y_b;
  logic [2:0] indice_b;
  logic       y_valido_b;
  logic       fim_b;

  int total = 0;
  int bad = 0;

  // model state: m_st 0 idle, 1 direct, 2 sweep
  int         m_st = 0;
  int         m_held = -1;
  int         m_base = 0;
  int         m_n = 0;
  bit         m_inh = 1'b0;
  logic [3:0] e_y = '0;
  logic [1:0] e_ind = '0;
  logic       e_v = 1'b0;
  logic       e_fim = 1'b0;

  always #5 clk = ~clk;

  decodificador_n_varredura #(
    .LARGURA(L),
    .PERMANENCIA(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .modo(modo),
    .inibe(inibe),
    .codigo(codigo),
    .codigo_valido(codigo_valido),
    .y(y),
    .indice(indice),
    .y_valido(y_valido),
    .fim_varredura(fim_varredura)
  );

  decodificador_n_varredura #(
    .LARGURA(3),
    .PERMANENCIA(1)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .modo(modo),
    .inibe(inibe),
    .codigo(codigo_b),
    .codigo_valido(codigo_valido),
    .y(y_b),
    .indice(indice_b),
    .y_valido(y_valido_b),
    .fim_varredura(fim_b)
  );

  // Sweep position is derived from edges elapsed since the last (re)start.
  function automatic void model_step();
    e_fim = 1'b0;
    if (rst) begin
      m_st = 0; m_held = -1; m_base = 0; m_n = 0;
      m_inh = 1'b0;
      e_y = '0; e_ind = '0; e_v = 1'b0;
      return;
    end
    if (inibe) begin
      e_y = '0; e_v = 1'b0; m_inh = 1'b1;
      return;
    end
    if (modo) begin
      if (m_st != 2) begin
        m_base = 0; m_n = 0;
      end else if (m_inh) begin
        m_base = int'(e_ind); m_n = 0;
      end else begin
        m_n = m_n + 1;
      end
      m_st = 2;
      e_ind = 2'((m_base + m_n / P) % S);
      e_fim = (m_n > 0) && (m_n % P == 0) && (e_ind == 2'd0);
      e_y = 4'b0001 << e_ind;
      e_v = 1'b1;
    end else begin
      if (codigo_valido) begin
        m_held = int'(codigo);
        e_ind = codigo;
      end else if (m_st == 2) begin
        m_held = -1;
      end
      if (codigo_valido || m_st == 2) m_st = 1;
      e_v = (m_held >= 0);
      e_y = e_v ? (4'b0001 << m_held) : 4'b0000;
    end
    m_inh = 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      modo = 1'($urandom);
      inibe = 1'($urandom);
      codigo = 2'($urandom);
      codigo_valido = 1'($urandom);
      tick();
      total++;
      if ({y, indice, y_valido, fim_varredura} !== 8'b0) begin
        bad++;
        $display("FAIL reset cyc=%0d got y=%b ind=%0d v=%b f=%b want all 0",
                 i, y, indice, y_valido, fim_varredura);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_direto();
    logic [3:0] w;
    do_reset();
    modo = 1'b0;
    inibe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      codigo = 2'(k);
      codigo_valido = 1'b1;
      tick();
      w = 4'b0001 << k;
      total++;
      if (y !== w || indice !== 2'(k) || y_valido !== 1'b1) begin
        bad++;
        $display("FAIL direto k=%0d got y=%b ind=%0d v=%b want y=%b ind=%0d v=1",
                 k, y, indice, y_valido, w, k);
      end
    end
    codigo_valido = 1'b0;
    for (int i = 0; i < 3; i++) begin
      codigo = 2'($urandom);
      tick();
      total++;
      if (y !== 4'b1000 || y_valido !== 1'b1) begin
        bad++;
        $display("FAIL direto_hold cyc=%0d got y=%b v=%b want y=1000 v=1",
                 i, y, y_valido);
      end
    end
  endtask

  task automatic test_varredura();
    logic [3:0] w;
    int pulses;
    pulses = 0;
    do_reset();
    modo = 1'b1;
    inibe = 1'b0;
    for (int i = 0; i < 20; i++) begin
      codigo = 2'($urandom);
      codigo_valido = 1'($urandom);
      tick();
      w = 4'b0001 << ((i / 4) % 4);
      if (fim_varredura === 1'b1) pulses++;
      total++;
      if (y !== w || y_valido !== 1'b1 ||
          fim_varredura !== (i == 16)) begin
        bad++;
        $display("FAIL varredura cyc=%0d got y=%b v=%b f=%b want y=%b v=1 f=%b",
                 i, y, y_valido, fim_varredura, w, (i == 16));
      end
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL varredura_pulses got=%0d want=1", pulses);
    end
  endtask

  task automatic test_inibe();
    do_reset();
    modo = 1'b1;
    inibe = 1'b0;
    repeat (9) tick();
    inibe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (y !== 4'b0000 || y_valido !== 1'b0 || indice !== 2'd2) begin
        bad++;
        $display("FAIL inibe_mask cyc=%0d got y=%b v=%b ind=%0d want y=0000 v=0 ind=2",
                 i, y, y_valido, indice);
      end
    end
    inibe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (y !== ((i < 4) ? 4'b0100 : 4'b1000)) begin
        bad++;
        $display("FAIL inibe_resume cyc=%0d got y=%b want %b",
                 i, y, (i < 4) ? 4'b0100 : 4'b1000);
      end
    end
    do_reset();
    modo = 1'b0;
    codigo = 2'd1;
    codigo_valido = 1'b1;
    tick();
    inibe = 1'b1;
    codigo = 2'd3;
    tick();
    total++;
    if (y !== 4'b0000 || y_valido !== 1'b0) begin
      bad++;
      $display("FAIL inibe_direto got y=%b v=%b want y=0000 v=0", y, y_valido);
    end
    inibe = 1'b0;
    codigo_valido = 1'b0;
    tick();
    total++;
    if (y !== 4'b0010 || indice !== 2'd1 || y_valido !== 1'b1) begin
      bad++;
      $display("FAIL inibe_discard got y=%b ind=%0d v=%b want y=0010 ind=1 v=1",
               y, indice, y_valido);
    end
  endtask

  task automatic test_reset_varredura();
    do_reset();
    modo = 1'b1;
    inibe = 1'b0;
    repeat (13) tick();
    total++;
    if (indice !== 2'd3) begin
      bad++;
      $display("FAIL rst_sweep_pre got ind=%0d want 3", indice);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (y !== 4'b0000 || y_valido !== 1'b0 || indice !== 2'd0) begin
      bad++;
      $display("FAIL rst_sweep_abort got y=%b v=%b ind=%0d want 0000 0 0",
               y, y_valido, indice);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (y !== ((i < 4) ? 4'b0001 : 4'b0010)) begin
        bad++;
        $display("FAIL rst_sweep_restart cyc=%0d got y=%b want %b",
                 i, y, (i < 4) ? 4'b0001 : 4'b0010);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      inibe = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 11) == 0) modo = ~modo;
      codigo = 2'($urandom);
      codigo_b = 3'($urandom);
      codigo_valido = ($urandom_range(0, 2) == 0);
      tick();
      total++;
      if ({y, indice, y_valido, fim_varredura} !==
          {e_y, e_ind, e_v, e_fim}) begin
        bad++;
        $display("FAIL random cyc=%0d got y=%b ind=%0d v=%b f=%b want y=%b ind=%0d v=%b f=%b",
                 i, y, indice, y_valido, fim_varredura,
                 e_y, e_ind, e_v, e_fim);
      end
      total++;
      if ($countones(y) > 1 || ((y != 0) !== y_valido) ||
          $countones(y_b) > 1 || ((y_b != 0) !== y_valido_b)) begin
        bad++;
        $display("FAIL invariant cyc=%0d got y=%b v=%b y_b=%b v_b=%b want onehot-or-zero matching valid",
                 i, y, y_valido, y_b, y_valido_b);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_l3();
    logic [7:0] w;
    do_reset();
    modo = 1'b1;
    inibe = 1'b0;
    for (int i = 0; i < 24; i++) begin
      codigo_b = 3'($urandom);
      tick();
      w = 8'h01 << (i % 8);
      total++;
      if (y_b !== w || indice_b !== 3'(i % 8) ||
          fim_b !== (i > 0 && i % 8 == 0) ||
          $countones(y_b) != 1) begin
        bad++;
        $display("FAIL l3_sweep cyc=%0d got y=%h ind=%0d f=%b want y=%h ind=%0d f=%b",
                 i, y_b, indice_b, fim_b, w, i % 8, (i > 0 && i % 8 == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_direto();
    test_varredura();
    test_inibe();
    test_reset_varredura();
    test_random();
    test_l3();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
